// File: rtl/triangle_monitor.sv
// Tracks an unsigned triangle-wave sample stream: locks onto +/-1 ramps, flags
// peak/trough reversals and step violations, and measures trough-to-trough period.
module triangle_monitor #(
   parameter int N = 8,
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic [N-1:0] sample,
   output logic         locked,
   output logic         dir,
   output logic         peak,
   output logic         trough,
   output logic         error,
   output logic [W-1:0] period,
   output logic         period_valid,
   output logic [W-1:0] err_count
);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      ACQUIRE = 2'd1,
      UP      = 2'd2,
      DOWN    = 2'd3
   } state_t;

   localparam logic [N-1:0] ONE_N = N'(1);
   localparam logic [W-1:0] ONE_W = W'(1);

   state_t       state_q, state_d;
   logic [N-1:0] prev_q, prev_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] period_q, period_d;
   logic [W-1:0] errc_q, errc_d;
   logic         seen_q, seen_d;
   logic         peak_q, peak_d;
   logic         trough_q, trough_d;
   logic         error_q, error_d;
   logic         pv_q, pv_d;

   logic [N-1:0] expect_v;
   logic         reversal;
   logic [W-1:0] cnt_inc;
   logic [W-1:0] errc_inc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= EMPTY;
         prev_q   <= '0;
         cnt_q    <= '0;
         period_q <= '0;
         errc_q   <= '0;
         seen_q   <= 1'b0;
         peak_q   <= 1'b0;
         trough_q <= 1'b0;
         error_q  <= 1'b0;
         pv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         errc_q   <= errc_d;
         seen_q   <= seen_d;
         peak_q   <= peak_d;
         trough_q <= trough_d;
         error_q  <= error_d;
         pv_q     <= pv_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      errc_d   = errc_q;
      seen_d   = seen_q;
      peak_d   = 1'b0;
      trough_d = 1'b0;
      error_d  = 1'b0;
      pv_d     = 1'b0;
      expect_v = '0;
      reversal = 1'b0;
      cnt_inc  = (&cnt_q)  ? cnt_q  : cnt_q + ONE_W;
      errc_inc = (&errc_q) ? errc_q : errc_q + ONE_W;

      if (ena) begin
         prev_d = sample;
         cnt_d  = cnt_inc;
         unique case (state_q)
            EMPTY: state_d = ACQUIRE;
            ACQUIRE: begin
               if (sample == prev_q + ONE_N) begin
                  state_d = UP;
               end else if (sample == prev_q - ONE_N) begin
                  state_d = DOWN;
               end
            end
            UP: begin
               reversal = (prev_q == '1);
               expect_v = reversal ? prev_q - ONE_N : prev_q + ONE_N;
            end
            DOWN: begin
               reversal = (prev_q == '0);
               expect_v = reversal ? ONE_N : prev_q - ONE_N;
            end
            default: state_d = EMPTY;
         endcase

         // Wraps through all-ones/zero fail here because expect_v holds the reversal value.
         if ((state_q == UP) || (state_q == DOWN)) begin
            if (sample != expect_v) begin
               error_d = 1'b1;
               errc_d  = errc_inc;
               state_d = ACQUIRE;
               seen_d  = 1'b0;
            end else if (reversal && (state_q == UP)) begin
               peak_d  = 1'b1;
               state_d = DOWN;
            end else if (reversal) begin
               trough_d = 1'b1;
               state_d  = UP;
               cnt_d    = '0;
               seen_d   = 1'b1;
               if (seen_q) begin
                  period_d = cnt_inc;
                  pv_d     = 1'b1;
               end
            end
         end
      end
   end

   assign locked       = (state_q == UP) || (state_q == DOWN);
   assign dir          = (state_q == DOWN);
   assign peak         = peak_q;
   assign trough       = trough_q;
   assign error        = error_q;
   assign period       = period_q;
   assign period_valid = pv_q;
   assign err_count    = errc_q;

endmodule

// File: tb/tb_triangle_monitor.sv
// Directed bench: a behavioural reference model feeds a scoreboard queue that is
// compared against the DUT one cycle after each driven sample.
module tb_triangle_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ena = 1'b0;
   logic [7:0]  sample = '0;
   logic        locked, dir, peak, trough, error, period_valid;
   logic [15:0] period, err_count;

   logic        ena3 = 1'b0;
   logic [2:0]  sample3 = '0;
   logic        locked3, dir3, peak3, trough3, error3, pv3;
   logic [3:0]  period3, err_count3;

   triangle_monitor #(.N(8), .W(16)) dut (
      .clk(clk), .rst(rst), .ena(ena), .sample(sample),
      .locked(locked), .dir(dir), .peak(peak), .trough(trough), .error(error),
      .period(period), .period_valid(period_valid), .err_count(err_count)
   );

   triangle_monitor #(.N(3), .W(4)) dut3 (
      .clk(clk), .rst(rst), .ena(ena3), .sample(sample3),
      .locked(locked3), .dir(dir3), .peak(peak3), .trough(trough3), .error(error3),
      .period(period3), .period_valid(pv3), .err_count(err_count3)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [37:0] exp_q[$];
   logic [7:0]  stim[$];

   // reference model state: 0 EMPTY, 1 ACQUIRE, 2 UP, 3 DOWN
   int       m_state, m_cnt, m_period, m_errc;
   logic [7:0] m_prev;
   bit       m_seen, m_peak, m_trough, m_err, m_pv;
   int       pv_cnt, peak_cnt, trough_cnt, idle_pulses, pv3_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_period = 0; m_errc = 0; m_prev = '0;
      m_seen = 0; m_peak = 0; m_trough = 0; m_err = 0; m_pv = 0;
   endtask

   task automatic model_step(input bit e, input logic [7:0] s);
      bit rev;
      logic [7:0] want;
      m_peak = 0; m_trough = 0; m_err = 0; m_pv = 0;
      if (!e) return;
      case (m_state)
         0: m_state = 1;
         1: begin
            if (s == 8'(m_prev + 8'd1)) m_state = 2;
            else if (s == 8'(m_prev - 8'd1)) m_state = 3;
         end
         default: begin
            if (m_state == 2) begin
               rev  = (m_prev == 8'hFF);
               want = rev ? 8'hFE : 8'(m_prev + 8'd1);
            end else begin
               rev  = (m_prev == 8'h00);
               want = rev ? 8'h01 : 8'(m_prev - 8'd1);
            end
            if (s != want) begin
               m_err = 1; m_state = 1; m_seen = 0;
               m_errc = (m_errc == 65535) ? 65535 : m_errc + 1;
            end else if (rev && m_state == 2) begin
               m_peak = 1; m_state = 3;
            end else if (rev) begin
               m_trough = 1; m_state = 2;
               if (m_seen) begin
                  m_pv = 1;
                  m_period = (m_cnt == 65535) ? 65535 : m_cnt + 1;
               end
               m_seen = 1;
            end
         end
      endcase
      if (m_trough) m_cnt = 0;
      else m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
      m_prev = s;
   endtask

   function automatic logic [37:0] model_vec();
      return {m_state >= 2, m_state == 3, m_peak, m_trough, m_err, m_pv,
              16'(m_period), 16'(m_errc)};
   endfunction

   function automatic logic [37:0] obs_vec();
      return {locked, locked & dir, peak, trough, error, period_valid, period, err_count};
   endfunction

   task automatic step(input bit e, input logic [7:0] s);
      logic [37:0] want;
      @(negedge clk);
      ena = e; sample = s;
      model_step(e, s);
      exp_q.push_back(model_vec());
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         want = exp_q.pop_front();
         check("scoreboard", 64'(obs_vec()), 64'(want));
      end
      pv_cnt     += int'(period_valid);
      peak_cnt   += int'(peak);
      trough_cnt += int'(trough);
      if (!e && (peak | trough | error | period_valid)) idle_pulses++;
   endtask

   task automatic step3(input logic [2:0] s);
      @(negedge clk);
      ena3 = 1'b1; sample3 = s;
      @(posedge clk);
      #1;
      pv3_cnt += int'(pv3);
   endtask

   task automatic apply_reset(input string tag);
      #2 rst = 1'b0;
      ena = 1'b0;
      #1 check(tag, 64'(obs_vec()), 64'd0);
      model_reset();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic add_ramp(input int a, input int b);
      if (a <= b) for (int v = a; v <= b; v++) stim.push_back(8'(v));
      else        for (int v = a; v >= b; v--) stim.push_back(8'(v));
   endtask

   task automatic clear_counts();
      pv_cnt = 0; peak_cnt = 0; trough_cnt = 0; idle_pulses = 0;
   endtask

   initial begin
      model_reset();
      clear_counts();
      pv3_cnt = 0;
      #1;
      check("reset_state", 64'(obs_vec()), 64'd0);
      check("reset_state3", 64'({locked3, pv3, period3, err_count3}), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Full-scale triangle, continuous ena
      stim.delete();
      add_ramp(0, 255); add_ramp(254, 0); add_ramp(1, 255); add_ramp(254, 0);
      stim.push_back(8'd1);
      foreach (stim[i]) begin
         step(1'b1, stim[i]);
         if (i == 1) check("lock_after_2nd", 64'({locked, dir}), 64'b10);
         if (i > 0 && stim[i-1] == 8'd255 && stim[i] == 8'd254) check("peak_after_255", 64'(peak), 64'd1);
      end
      check("period_510", 64'(period), 64'd510);
      check("pv_count", 64'(pv_cnt), 64'd1);
      check("peak_count", 64'(peak_cnt), 64'd2);
      check("errc_zero", 64'(err_count), 64'd0);
      $display("txn: continuous stream samples=%0d period=%0d", stim.size(), period);

      // Same stream with ena alternating
      apply_reset("reset_between");
      clear_counts();
      foreach (stim[i]) begin
         step(1'b1, stim[i]);
         step(1'b0, 8'($urandom_range(0, 255)));
      end
      check("gated_period_510", 64'(period), 64'd510);
      check("gated_pv_count", 64'(pv_cnt), 64'd1);
      check("gated_troughs", 64'(trough_cnt), 64'd2);
      check("gated_idle_pulses", 64'(idle_pulses), 64'd0);
      $display("txn: gated stream period=%0d", period);

      // Step violation and relock
      apply_reset("reset_before_err");
      step(1'b1, 8'd10);
      step(1'b1, 8'd11);
      step(1'b1, 8'd13);
      check("err_after_13", 64'({error, locked, err_count}), 64'({1'b1, 1'b0, 16'd1}));
      step(1'b1, 8'd14);
      check("relock_after_14", 64'({locked, dir}), 64'b10);
      step(1'b1, 8'd15);
      $display("txn: step violation err_count=%0d", err_count);

      // Wraps are violations, not reversals
      for (int v = 16; v <= 255; v++) step(1'b1, 8'(v));
      step(1'b1, 8'd0);
      check("wrap_up_err", 64'({error, peak}), 64'b10);
      step(1'b1, 8'd2);
      step(1'b1, 8'd1);
      step(1'b1, 8'd0);
      check("down_locked", 64'({locked, dir}), 64'b11);
      step(1'b1, 8'd255);
      check("wrap_dn_err", 64'({error, trough, err_count}), 64'({1'b1, 1'b0, 16'd3}));
      $display("txn: wrap violations err_count=%0d", err_count);

      // Asynchronous reset mid-descent
      apply_reset("reset_before_async");
      clear_counts();
      stim.delete();
      add_ramp(0, 255); add_ramp(254, 0); add_ramp(1, 255); add_ramp(254, 100);
      foreach (stim[i]) step(1'b1, stim[i]);
      check("mid_down", 64'({locked, dir, trough_cnt[1:0]}), 64'({2'b11, 2'd1}));
      apply_reset("async_reset_zero");
      clear_counts();
      for (int v = 99; v >= 0; v--) step(1'b1, 8'(v));
      step(1'b1, 8'd1);
      check("first_trough_no_pv", 64'({trough, period_valid, period}), 64'({2'b10, 16'd0}));
      for (int v = 2; v <= 255; v++) step(1'b1, 8'(v));
      for (int v = 254; v >= 0; v--) step(1'b1, 8'(v));
      step(1'b1, 8'd1);
      check("post_reset_period", 64'({period_valid, period}), 64'({1'b1, 16'd510}));
      $display("txn: async reset recovery period=%0d", period);

      // Narrow instance: N=3 period and W=4 error saturation
      for (int c = 0; c < 2; c++) begin
         for (int v = (c == 0) ? 0 : 1; v <= 7; v++) step3(3'(v));
         for (int v = 6; v >= 0; v--) step3(3'(v));
      end
      step3(3'd1);
      check("n3_period_14", 64'({pv3, period3}), 64'({1'b1, 4'd14}));
      check("n3_pv_count", 64'(pv3_cnt), 64'd1);
      for (int k = 0; k < 17; k++) begin
         step3(3'd0); step3(3'd1); step3(3'd3);
      end
      check("n3_errc_sat", 64'(err_count3), 64'd15);
      $display("txn: narrow instance period=%0d err_count=%0d", period3, err_count3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
